// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, column
// drive patterns, and the column/row -> hex code map.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  localparam logic [3:0] COL0 = 4'b0111;
  localparam logic [3:0] COL1 = 4'b1011;
  localparam logic [3:0] COL2 = 4'b1101;
  localparam logic [3:0] COL3 = 4'b1110;

  typedef struct packed {
    logic       vld;
    logic [3:0] code;
  } key_t;

  function automatic logic one_cold(input logic [3:0] row);
    return (row == 4'b0111) || (row == 4'b1011) ||
           (row == 4'b1101) || (row == 4'b1110);
  endfunction

  // Rotate right so the low column walks 0111 -> 1011 -> 1101 -> 1110.
  function automatic logic [3:0] next_col(input logic [3:0] c);
    return {c[0], c[3:1]};
  endfunction

  function automatic key_t key_lookup(input logic [3:0] c, input logic [3:0] row);
    key_t       k;
    logic [1:0] ci, ri;
    logic       cv, rv;
    cv = 1'b1;
    rv = 1'b1;
    ci = 2'd0;
    ri = 2'd0;
    unique case (c)
      COL0:    ci = 2'd0;
      COL1:    ci = 2'd1;
      COL2:    ci = 2'd2;
      COL3:    ci = 2'd3;
      default: cv = 1'b0;
    endcase
    unique case (row)
      4'b0111: ri = 2'd0;
      4'b1011: ri = 2'd1;
      4'b1101: ri = 2'd2;
      4'b1110: ri = 2'd3;
      default: rv = 1'b0;
    endcase
    k.vld = cv && rv;
    unique case ({ci, ri})
      4'd0:    k.code = 4'h1;
      4'd1:    k.code = 4'h4;
      4'd2:    k.code = 4'h7;
      4'd3:    k.code = 4'hE;
      4'd4:    k.code = 4'h2;
      4'd5:    k.code = 4'h5;
      4'd6:    k.code = 4'h8;
      4'd7:    k.code = 4'h0;
      4'd8:    k.code = 4'h3;
      4'd9:    k.code = 4'h6;
      4'd10:   k.code = 4'h9;
      4'd11:   k.code = 4'hF;
      4'd12:   k.code = 4'hA;
      4'd13:   k.code = 4'hB;
      4'd14:   k.code = 4'hC;
      default: k.code = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so idle
// active-low lines read as released.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks a one-cold column, debounces a single-row hit,
// and emits exactly one key_valid strobe per physical press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS      = 64,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int TW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TICK_END = TW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DEB_END  = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    fil_s;
  logic [3:0]    row_lat;
  logic [TW-1:0] tick;
  logic [DW-1:0] deb;
  state_t        state;
  key_t          hit;

  sync_2ff #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (fil),
    .q   (fil_s)
  );

  always_comb hit = key_lookup(col, row_lat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      col       <= COL0;
      row_lat   <= 4'b1111;
      tick      <= '0;
      deb       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          // Rows are only trusted at dwell end, after sync + settling.
          if (tick == TICK_END) begin
            tick <= '0;
            if (one_cold(fil_s)) begin
              row_lat <= fil_s;
              deb     <= '0;
              state   <= DEB_PRESS;
            end else begin
              col <= next_col(col);
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (fil_s != row_lat) begin
            tick  <= '0;
            state <= SCAN;
          end else if (deb == DEB_END) begin
            if (hit.vld) begin
              key_valid <= 1'b1;
              key_code  <= hit.code;
              key_held  <= 1'b1;
              state     <= HELD;
            end else begin
              tick  <= '0;
              state <= SCAN;
            end
          end else begin
            deb <= deb + 1'b1;
          end
        end
        HELD: begin
          if (fil_s == 4'b1111) begin
            deb   <= '0;
            state <= DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          // Any row activity means the key is still down: no second strobe.
          if (fil_s != 4'b1111) begin
            state <= HELD;
          end else if (deb == DEB_END) begin
            key_held <= 1'b0;
            col      <= next_col(col);
            tick     <= '0;
            state    <= SCAN;
          end else begin
            deb <= deb + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule
